m_ll_queue: RTL

M_LL_QUEUE -- requirements
Module: m_ll_queue

---
 rtl/m_ll_queue_if.sv | 34 +++
 rtl/m_ll_queue.sv | 96 +++++++++
 2 files changed

// File: rtl/m_ll_queue_if.sv
// Handshake bundle for m_ll_queue: free-list allocate/return, push/pop channels, status.
// The queue takes the slave side; the environment that feeds it takes the master side.
interface m_ll_queue_if #(
    parameter int EN = 64,
    parameter int DW = 32
);
    localparam int CNT_WDT = $clog2(EN + 1);

    logic               flush;
    logic               fl_vld;
    logic               fl_rdy;
    logic [EN-1:0]      fl;
    logic               ret_vld;
    logic               ret_rdy;
    logic [EN-1:0]      ret;
    logic               push_vld;
    logic               push_rdy;
    logic [DW-1:0]      push_data;
    logic               pop_vld;
    logic               pop_rdy;
    logic [DW-1:0]      pop_data;
    logic [CNT_WDT-1:0] cnt;
    logic               err;

    modport slave (
        input  flush, fl_vld, fl, ret_rdy, push_vld, push_data, pop_rdy,
        output fl_rdy, ret_vld, ret, push_rdy, pop_vld, pop_data, cnt, err
    );

    modport master (
        output flush, fl_vld, fl, ret_rdy, push_vld, push_data, pop_rdy,
        input  fl_rdy, ret_vld, ret, push_rdy, pop_vld, pop_data, cnt, err
    );
endinterface

// File: rtl/m_ll_queue.sv
// Singly linked FIFO built on nodes handed out by an external free list; popped nodes are
// returned one per cycle through a single-entry return register.
module m_ll_queue #(
    parameter int EN = 64,
    parameter int DW = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    m_ll_queue_if.slave  q
);
    localparam int L2_EN   = $clog2(EN);
    localparam int CNT_WDT = $clog2(EN + 1);

    logic [DW-1:0]      data_mem [EN];
    logic [L2_EN-1:0]   next_mem [EN];
    logic [L2_EN-1:0]   head, tail, idx;
    logic [CNT_WDT-1:0] cnt;
    logic [EN-1:0]      ret;
    logic               ret_vld, err;
    logic               push_strb, pop_strb, fl_ok, full, push_ok, empty_eff, pop_vld;

    always_comb begin
        idx = '0;
        for (int i = 0; i < EN; i++)
            if (q.fl[i]) idx = idx | L2_EN'(i);
    end

    assign q.push_rdy = q.fl_vld & ~q.flush;
    assign q.fl_rdy   = q.push_vld & ~q.flush;
    assign push_strb  = q.push_vld & q.push_rdy;

    // A malformed or overflowing allocation is flagged and dropped so the links stay intact.
    assign fl_ok     = (q.fl != '0) && ((q.fl & (q.fl - EN'(1))) == '0);
    assign full      = (cnt == CNT_WDT'(EN));
    assign push_ok   = push_strb & fl_ok & ~full;

    // Holding back pops while the return register is stuck keeps returns strictly ordered.
    assign pop_vld   = (cnt != '0) & (~ret_vld | q.ret_rdy) & ~q.flush;
    assign pop_strb  = pop_vld & q.pop_rdy;
    assign empty_eff = (cnt == '0) | ((cnt == CNT_WDT'(1)) & pop_strb);

    assign q.pop_vld  = pop_vld;
    assign q.pop_data = data_mem[head];
    assign q.ret_vld  = ret_vld;
    assign q.ret      = ret;
    assign q.cnt      = cnt;
    assign q.err      = err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head    <= '0;
            tail    <= '0;
            cnt     <= '0;
            ret     <= '0;
            ret_vld <= 1'b0;
            err     <= 1'b0;
        end else if (q.flush) begin
            head    <= '0;
            tail    <= '0;
            cnt     <= '0;
            ret     <= '0;
            ret_vld <= 1'b0;
            err     <= 1'b0;
        end else begin
            if (push_strb & ~(fl_ok & ~full))
                err <= 1'b1;

            if (pop_strb) begin
                head    <= next_mem[head];
                ret     <= EN'(1) << head;
                ret_vld <= 1'b1;
            end else if (ret_vld & q.ret_rdy) begin
                ret_vld <= 1'b0;
            end

            // Push into an (effectively) empty list overrides the pop's stale head advance.
            if (push_ok) begin
                tail <= idx;
                if (empty_eff) head <= idx;
            end

            case ({push_ok, pop_strb})
                2'b10:   cnt <= cnt + CNT_WDT'(1);
                2'b01:   cnt <= cnt - CNT_WDT'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            data_mem[idx] <= q.push_data;
            if (!empty_eff) next_mem[tail] <= idx;
        end
    end
endmodule
